pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter and fetch-sequencing stage of the single-cycle core. Holds the PC, addresses instruction memory, and hands the fetched word's opCode/funct fields to the control decoder. It consumes the decoder's Branch/Jump/PcSrc outputs, the ALU zero flag and operand data to compute the next PC. A small run/halt state machine starts execution on command, freezes on a halt word, and counts retired instructions.

## Interface
- PC_W, 8: PC width in words; instruction memory depth is 2^PC_W.
- RESET_PC, 0: PC value after reset.
- HALT_INSTR, 32'hFFFF_FFFF: instruction word that halts the core.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; leaves IDLE.
- stall  in  1  holds PC and counter for the cycle.
- instr_in  in  32  instruction memory read data at imem_addr (asynchronous read).
- Branch, Jump, PcSrc  in  1 each  decoder outputs for the current instruction.
- zero  in  1  ALU zero flag (rs − rt == 0).
- imm_ext  in  32  sign-extended 16-bit immediate.
- rs_data  in  32  register-file rs read data (jr target).
- imem_addr  out  PC_W  current PC.
- opCode  out  6  instr_in[31:26]; funct  out  6  instr_in[5:0].
- jtarget  out  26  instr_in[25:0].
- link_addr  out  32  zero-extended PC+1 (jal write-back data).
- running  out  1  state == RUN.
- halted  out  1  state == HALT.
- retired  out  32  retired-instruction count.

## Operation
- States: IDLE, RUN, HALT. Reset → IDLE, PC=RESET_PC, retired=0.
- IDLE: PC holds; start=1 → RUN next cycle. PC does not advance in IDLE.
- RUN, stall=1: PC, retired, state all hold.
- RUN, stall=0, instr_in==HALT_INSTR: → HALT; PC holds on halt word; retired not incremented.
- RUN, stall=0, otherwise: PC ← next_pc; retired ← retired+1.
- HALT: sticky; only rst exits. start ignored.
- next_pc priority, all arithmetic modulo 2^PC_W:
  - PcSrc=1, Jump=1 (jal): jtarget[PC_W-1:0].
  - PcSrc=1, Jump=0 (jr): rs_data[PC_W-1:0].
  - Branch=1 and taken: PC+1+imm_ext[PC_W-1:0]; taken = zero for opCode 6'h04 (beq), !zero for opCode 6'h05 (bne).
  - Otherwise: PC+1.
- Word-addressed PC; PC_W ≤ 26 required.
- opCode/funct/jtarget are pure slices of instr_in, valid in every state.

## Timing
- Single-cycle: instr_in, decode, and redirect resolve combinationally within the cycle; new PC is visible on imem_addr one cycle after the edge.
- Reset dominates start, stall, and halt in the same cycle.
- start and stall together in IDLE: → RUN; PC unchanged.
- Halt word with stall=1: no transition until stall drops.
- Reset mid-RUN or in HALT: next cycle IDLE, PC=RESET_PC, retired=0.
- PC wraps: PC=2^PC_W−1 sequential → 0; branch targets wrap identically.
- retired wraps 2^32−1 → 0.

## Structure
- Shared package/include isa_defs: opcode constants (beq 6'h04, bne 6'h05, jal 6'h03), HALT_INSTR default, and state encodings IDLE/RUN/HALT. The decoder uses the same opcode constants.
- One combinational sub-module, next_pc_sel: computes next_pc from PC, control signals, zero, imm_ext, jtarget, and rs_data. The top level holds the FSM, PC register, and counter.

## Test plan
- Reset, start at cycle 2, imem of sequential non-control words → imem_addr 0,0,1,2,3; retired 0,0,1,2,3.
- beq at PC 4, zero=1, imm_ext=−3 → next imem_addr 2. Same with zero=0 → 5. bne with zero=0, imm_ext=+2 → 7.
- jal jtarget=0x30 at PC 9 → link_addr=10, next PC 0x30. jr with rs_data=0x1_0012 → next PC 0x12 (truncated).
- Halt word at PC 6 with stall=1 for 3 cycles → running stays 1 and PC stays 6; stall drops → halted=1, PC stays 6, retired frozen. start then ignored.
- PC=255 (PC_W=8), sequential → 0. Branch at 250 with imm_ext=+10 → 5.
- rst asserted in RUN at PC 0x40 with stall=1 and start=1 → next cycle IDLE, PC 0, retired 0.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit_pkg
// Shared ISA definitions for the fetch stage and the control decoder:
// opcode constants, the default halt word, and the run/halt state encoding.
// ---------------------------------------------------------------------------
package pc_fetch_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    // beq redirects on equal operands, bne on unequal ones.
    function automatic logic branch_taken(input logic [5:0] op, input logic zero);
        return ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit_if
// Bus between the fetch stage, instruction memory and the decode/execute side.
//   master (fetch unit): drives imem_addr, opCode, funct, jtarget, link_addr;
//                        receives instr_in, Branch, Jump, PcSrc, zero,
//                        imm_ext, rs_data.
//   slave  (memory/decoder/datapath): the reverse.
// ---------------------------------------------------------------------------
interface pc_fetch_unit_if #(
    parameter int PC_W = 8
);
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     instr_in;
    logic [5:0]      opCode;
    logic [5:0]      funct;
    logic [25:0]     jtarget;
    logic [31:0]     link_addr;
    logic            Branch;
    logic            Jump;
    logic            PcSrc;
    logic            zero;
    logic [31:0]     imm_ext;
    logic [31:0]     rs_data;

    modport master (
        output imem_addr, opCode, funct, jtarget, link_addr,
        input  instr_in, Branch, Jump, PcSrc, zero, imm_ext, rs_data
    );

    modport slave (
        input  imem_addr, opCode, funct, jtarget, link_addr,
        output instr_in, Branch, Jump, PcSrc, zero, imm_ext, rs_data
    );
endinterface

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit_next_pc_sel
// Combinational next-PC selection. Priority: jal target, jr register target,
// taken branch (PC+1+imm), sequential PC+1. All sums wrap modulo 2^PC_W.
//   pc, opcode, branch, jump, pcsrc, zero : current PC and control
//   imm_ext, rs_data                      : 32-bit operands (low PC_W bits used)
//   jtarget_lo                            : jump target already cut to PC_W
//   next_pc                               : selected next PC
// ---------------------------------------------------------------------------
module pc_fetch_unit_next_pc_sel
    import pc_fetch_unit_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic [PC_W-1:0] pc,
    input  logic [5:0]      opcode,
    input  logic            branch,
    input  logic            jump,
    input  logic            pcsrc,
    input  logic            zero,
    input  logic [31:0]     imm_ext,
    input  logic [31:0]     rs_data,
    input  logic [PC_W-1:0] jtarget_lo,
    output logic [PC_W-1:0] next_pc
);
    logic [PC_W-1:0] pc_seq;
    logic [PC_W-1:0] pc_br;

    // Upper operand bits fall outside the word-address space.
    logic unused_hi;
    assign unused_hi = ^{imm_ext[31:PC_W], rs_data[31:PC_W]};

    assign pc_seq = pc + {{(PC_W-1){1'b0}}, 1'b1};
    assign pc_br  = pc_seq + imm_ext[PC_W-1:0];

    always_comb begin
        next_pc = pc_seq;
        if (pcsrc && jump) begin
            next_pc = jtarget_lo;
        end else if (pcsrc) begin
            next_pc = rs_data[PC_W-1:0];
        end else if (branch && branch_taken(opcode, zero)) begin
            next_pc = pc_br;
        end
    end
endmodule

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
// PC register, instruction fetch addressing and run/halt sequencing for the
// single-cycle core.
//   clk, rst      : clock, synchronous active-high reset
//   start         : pulse that leaves IDLE
//   stall         : freezes PC, counter and state for the cycle while running
//   bus (master)  : imem address/data, decoded fields, redirect controls,
//                   jal link address
//   running       : state is RUN
//   halted        : state is HALT (sticky until reset)
//   retired       : retired-instruction count (wraps at 2^32)
// The bus interface must be instantiated with the same PC_W as this module.
// ---------------------------------------------------------------------------
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int              PC_W       = 8,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter logic [31:0]     HALT_INSTR = HALT_WORD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stall,
    pc_fetch_unit_if.master    bus,
    output logic               running,
    output logic               halted,
    output logic [31:0]        retired
);
    fetch_state_e    state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] next_pc;

    assign bus.imem_addr = pc;
    assign bus.opCode    = bus.instr_in[31:26];
    assign bus.funct     = bus.instr_in[5:0];
    assign bus.jtarget   = bus.instr_in[25:0];

    assign pc_inc        = pc + {{(PC_W-1){1'b0}}, 1'b1};
    assign bus.link_addr = {{(32-PC_W){1'b0}}, pc_inc};

    pc_fetch_unit_next_pc_sel #(
        .PC_W(PC_W)
    ) u_next_pc_sel (
        .pc         (pc),
        .opcode     (bus.instr_in[31:26]),
        .branch     (bus.Branch),
        .jump       (bus.Jump),
        .pcsrc      (bus.PcSrc),
        .zero       (bus.zero),
        .imm_ext    (bus.imm_ext),
        .rs_data    (bus.rs_data),
        .jtarget_lo (bus.instr_in[PC_W-1:0]),
        .next_pc    (next_pc)
    );

    // running/halted are registered alongside the state they decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            pc      <= RESET_PC;
            retired <= '0;
            running <= 1'b0;
            halted  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        // The halt word is not retired and the PC stays on it.
                        if (bus.instr_in == HALT_INSTR) begin
                            state   <= ST_HALT;
                            running <= 1'b0;
                            halted  <= 1'b1;
                        end else begin
                            pc      <= next_pc;
                            retired <= retired + 32'd1;
                        end
                    end
                end
                ST_HALT: begin
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                    halted  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
// Bench for pc_fetch_unit with PC_W=8: behavioural imem and decoder, a
// reference model feeding a scoreboard queue, and literal checks of the
// program-flow scenarios.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;
    import pc_fetch_unit_pkg::*;

    localparam int PC_W = 8;
    localparam logic [31:0] NOP = 32'h0000_0020;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stall;
    logic        running;
    logic        halted;
    logic [31:0] retired;
    logic        zero_r;
    logic [31:0] rs_r;
    logic [31:0] imem [0:255];

    pc_fetch_unit_if #(.PC_W(PC_W)) bus();

    assign bus.instr_in = imem[bus.imem_addr];
    assign bus.Branch   = (bus.opCode == OP_BEQ) || (bus.opCode == OP_BNE);
    assign bus.Jump     = (bus.opCode == OP_JAL);
    assign bus.PcSrc    = (bus.opCode == OP_JAL) ||
                          ((bus.opCode == OP_RTYPE) && (bus.funct == 6'h08));
    assign bus.zero     = zero_r;
    assign bus.imm_ext  = {{16{bus.instr_in[15]}}, bus.instr_in[15:0]};
    assign bus.rs_data  = rs_r;

    pc_fetch_unit #(.PC_W(PC_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stall   (stall),
        .bus     (bus),
        .running (running),
        .halted  (halted),
        .retired (retired)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string       tag;
        logic [7:0]  pc;
        logic [31:0] ret;
        logic        run;
        logic        hlt;
    } exp_t;
    exp_t sb[$];

    // Reference model: 0 idle, 1 run, 2 halt
    int          m_st;
    logic [7:0]  m_pc;
    logic [31:0] m_ret;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_next(input logic [31:0] w, input logic [7:0] pc,
                                            input logic z, input logic [31:0] rs);
        logic [5:0] op;
        op = w[31:26];
        if (op == 6'h03) return w[7:0];
        if (op == 6'h00 && w[5:0] == 6'h08) return rs[7:0];
        if ((op == 6'h04 && z) || (op == 6'h05 && !z)) return pc + 8'd1 + w[7:0];
        return pc + 8'd1;
    endfunction

    task automatic step(input string tag, input logic r, input logic s, input logic st);
        logic [31:0] w;
        exp_t        e;
        rst   = r;
        start = s;
        stall = st;
        @(negedge clk);
        w = imem[m_pc];
        chk({tag, ".op"},   32'(bus.opCode),  32'(w[31:26]));
        chk({tag, ".fn"},   32'(bus.funct),   32'(w[5:0]));
        chk({tag, ".jt"},   32'(bus.jtarget), 32'(w[25:0]));
        chk({tag, ".link"}, bus.link_addr,    {24'd0, 8'(m_pc + 8'd1)});
        if (r) begin
            m_st = 0; m_pc = 8'd0; m_ret = 32'd0;
        end else begin
            case (m_st)
                0: if (s) m_st = 1;
                1: if (!st) begin
                    if (w == 32'hFFFF_FFFF) m_st = 2;
                    else begin
                        m_pc  = ref_next(w, m_pc, zero_r, rs_r);
                        m_ret = m_ret + 32'd1;
                    end
                end
                default: ;
            endcase
        end
        e = '{tag, m_pc, m_ret, (m_st == 1), (m_st == 2)};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".pc"},  32'(bus.imem_addr), 32'(e.pc));
        chk({e.tag, ".ret"}, retired,            e.ret);
        chk({e.tag, ".run"}, 32'(running),       32'(e.run));
        chk({e.tag, ".hlt"}, 32'(halted),        32'(e.hlt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = NOP;
        imem[4]     = {6'h04, 5'd1, 5'd2, 16'hFFFD};   // beq -3
        imem[6]     = 32'hFFFF_FFFF;                   // halt
        imem[9]     = {6'h03, 26'h30};                 // jal 0x30
        imem[8'h30] = {6'h00, 5'd3, 15'd0, 6'h08};     // jr
        imem[250]   = {6'h04, 10'd0, 16'd10};          // beq +10
        zero_r = 1'b0; rs_r = 32'd0;
        rst = 1'b1; start = 1'b0; stall = 1'b0;
        m_st = 0; m_pc = 8'd0; m_ret = 32'd0;

        // Reset and sequential fetch
        step("rst", 1, 0, 0);
        chk("rst_addr", 32'(bus.imem_addr), 32'd0);
        chk("rst_ret", retired, 32'd0);
        chk("rst_run", 32'(running), 32'd0);
        step("idle", 0, 0, 0);
        chk("idle_addr", 32'(bus.imem_addr), 32'd0);
        step("start", 0, 1, 0);
        for (int i = 0; i < 4; i++) step("seq", 0, 0, 0);
        chk("seq_addr", 32'(bus.imem_addr), 32'd4);
        chk("seq_ret", retired, 32'd4);

        // beq taken / not taken
        zero_r = 1'b1;
        step("beq_t", 0, 0, 0);
        chk("beq_t_addr", 32'(bus.imem_addr), 32'd2);
        zero_r = 1'b0;
        step("seq", 0, 0, 0);
        step("seq", 0, 0, 0);
        step("beq_nt", 0, 0, 0);
        chk("beq_nt_addr", 32'(bus.imem_addr), 32'd5);

        // bne, jal, jr
        imem[4] = {6'h05, 10'd0, 16'd2};
        step("rst2", 1, 0, 0);
        step("start2", 0, 1, 0);
        for (int i = 0; i < 4; i++) step("seq", 0, 0, 0);
        step("bne", 0, 0, 0);
        chk("bne_addr", 32'(bus.imem_addr), 32'd7);
        step("seq", 0, 0, 0);
        step("seq", 0, 0, 0);
        chk("jal_link", bus.link_addr, 32'd10);
        step("jal", 0, 0, 0);
        chk("jal_addr", 32'(bus.imem_addr), 32'h30);
        rs_r = 32'h0001_0012;
        step("jr", 0, 0, 0);
        chk("jr_addr", 32'(bus.imem_addr), 32'h12);

        // Halt with stall
        step("rst3", 1, 0, 0);
        zero_r = 1'b1;
        step("start3", 0, 1, 0);
        for (int i = 0; i < 6; i++) step("seq", 0, 0, 0);
        chk("halt_pc", 32'(bus.imem_addr), 32'd6);
        for (int i = 0; i < 3; i++) step("hstall", 0, 0, 1);
        chk("hstall_run", 32'(running), 32'd1);
        chk("hstall_pc", 32'(bus.imem_addr), 32'd6);
        step("halt", 0, 0, 0);
        chk("halt_hlt", 32'(halted), 32'd1);
        chk("halt_ret", retired, 32'd6);
        step("halt_start", 0, 1, 0);
        chk("halt_sticky", 32'(halted), 32'd1);
        chk("halt_pc2", 32'(bus.imem_addr), 32'd6);

        // PC wrap and wrapped branch
        imem[0] = {6'h00, 5'd3, 15'd0, 6'h08};
        rs_r = 32'd255;
        step("rst4", 1, 0, 0);
        step("start4", 0, 1, 0);
        step("jr255", 0, 0, 0);
        chk("jr255_addr", 32'(bus.imem_addr), 32'd255);
        step("wrap", 0, 0, 0);
        chk("wrap_addr", 32'(bus.imem_addr), 32'd0);
        rs_r = 32'd250;
        step("jr250", 0, 0, 0);
        step("brwrap", 0, 0, 0);
        chk("brwrap_addr", 32'(bus.imem_addr), 32'd5);

        // start+stall in IDLE, then reset dominating in RUN
        step("rst5", 1, 0, 0);
        step("start_stall", 0, 1, 1);
        chk("ss_run", 32'(running), 32'd1);
        chk("ss_pc", 32'(bus.imem_addr), 32'd0);
        rs_r = 32'h40;
        step("jr40", 0, 0, 0);
        chk("jr40_addr", 32'(bus.imem_addr), 32'h40);
        step("rst_run", 1, 1, 1);
        chk("rr_pc", 32'(bus.imem_addr), 32'd0);
        chk("rr_ret", retired, 32'd0);
        chk("rr_run", 32'(running), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
